// File: rtl/pwr_seq_ctrl.sv
// Power-rail sequencing controller.
// Brings rails up in index order, with a timer-driven delay before each rail and
// a power-good wait after it. Brings them down in reverse order with a fixed
// delay between disables. Enabled rails are supervised, and any power-good loss
// drops every rail and latches a fault.
module pwr_seq_ctrl #(
   parameter int N_RAILS    = 4,
   parameter int IW         = 2,
   parameter int DW         = 32,
   parameter int PG_TIMEOUT = 1000,
   parameter int DN_DELAY   = 100
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear_fault,
   input  logic [N_RAILS*DW-1:0] delay_up,
   input  logic [N_RAILS-1:0]    pgood,
   input  logic                  tmr_timeout,
   output logic                  tmr_load,
   output logic [DW-1:0]         tmr_data,
   output logic                  tmr_en,
   output logic [N_RAILS-1:0]    rail_en,
   output logic                  pwr_ok,
   output logic                  busy,
   output logic                  fault,
   output logic [IW-1:0]         fault_rail
);

   localparam logic [2:0] ST_OFF     = 3'd0;
   localparam logic [2:0] ST_UP_LOAD = 3'd1;
   localparam logic [2:0] ST_UP_WAIT = 3'd2;
   localparam logic [2:0] ST_UP_PG   = 3'd3;
   localparam logic [2:0] ST_ON      = 3'd4;
   localparam logic [2:0] ST_DN_LOAD = 3'd5;
   localparam logic [2:0] ST_DN_WAIT = 3'd6;
   localparam logic [2:0] ST_FAULT   = 3'd7;

   localparam logic [IW-1:0] LAST_IDX    = IW'(N_RAILS - 1);
   localparam logic [31:0]   PG_LAST     = 32'(PG_TIMEOUT - 1);
   localparam logic [DW-1:0] DN_LOAD_VAL = DW'(DN_DELAY);

   logic [2:0]         r_state;
   logic [IW-1:0]      r_idx;
   logic [31:0]        r_pg_cnt;
   logic [N_RAILS-1:0] r_rail_en;
   logic [IW-1:0]      r_fault_rail;

   logic [2:0]         w_nxt_state;
   logic [IW-1:0]      w_nxt_idx;
   logic [31:0]        w_nxt_pg_cnt;
   logic [N_RAILS-1:0] w_nxt_rail_en;
   logic [IW-1:0]      w_nxt_fault_rail;

   logic               w_up_state;
   logic               w_dn_state;
   logic               w_abort;
   logic [N_RAILS-1:0] w_sup_mask;
   logic [N_RAILS-1:0] w_bad;
   logic [IW-1:0]      w_bad_idx;
   logic               w_sup_fail;
   logic [DW-1:0]      w_delay_arr [N_RAILS];

   for (genvar g = 0; g < N_RAILS; g++) begin : g_delay
      assign w_delay_arr[g] = delay_up[g*DW +: DW];
   end

   assign w_up_state = (r_state == ST_UP_LOAD) || (r_state == ST_UP_WAIT) || (r_state == ST_UP_PG);
   assign w_dn_state = (r_state == ST_DN_LOAD) || (r_state == ST_DN_WAIT);
   assign w_abort    = stop || !start;
   assign w_sup_fail = |w_bad;

   // Supervision: find the lowest enabled rail that has lost power-good.
   always_comb begin
      w_sup_mask = '0;
      for (int j = 0; j < N_RAILS; j++) begin
         w_sup_mask[j] = (r_state == ST_ON) || (w_up_state && (IW'(j) < r_idx));
      end
      w_bad     = w_sup_mask & r_rail_en & ~pgood;
      w_bad_idx = '0;
      // Walk downwards so the lowest failing rail is the one that sticks.
      for (int j = N_RAILS - 1; j >= 0; j--) begin
         if (w_bad[j]) w_bad_idx = IW'(j);
      end
   end

   // Next-state and datapath update for the sequencer.
   always_comb begin
      // NOTE: every target gets a default before the case, so no branch can infer a latch.
      w_nxt_state      = r_state;
      w_nxt_idx        = r_idx;
      w_nxt_pg_cnt     = r_pg_cnt;
      w_nxt_rail_en    = r_rail_en;
      w_nxt_fault_rail = r_fault_rail;
      if (w_sup_fail) begin
         w_nxt_state      = ST_FAULT;
         w_nxt_rail_en    = '0;
         w_nxt_fault_rail = w_bad_idx;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (!stop && start) begin
                  w_nxt_state = ST_UP_LOAD;
                  w_nxt_idx   = '0;
               end
            end
            ST_UP_LOAD, ST_UP_WAIT: begin
               if (w_abort) begin
                  // Rail idx is not on yet, so unwinding starts one rail lower.
                  if (r_idx == '0) begin
                     w_nxt_state = ST_OFF;
                  end else begin
                     w_nxt_state = ST_DN_LOAD;
                     w_nxt_idx   = r_idx - IW'(1);
                  end
               end else if (r_state == ST_UP_LOAD) begin
                  w_nxt_state = ST_UP_WAIT;
               end else if (tmr_timeout) begin
                  w_nxt_rail_en[r_idx] = 1'b1;
                  w_nxt_pg_cnt         = '0;
                  w_nxt_state          = ST_UP_PG;
               end
            end
            ST_UP_PG: begin
               if (w_abort) begin
                  w_nxt_state = ST_DN_LOAD;
               end else if (pgood[r_idx]) begin
                  if (r_idx == LAST_IDX) begin
                     w_nxt_state = ST_ON;
                  end else begin
                     w_nxt_idx   = r_idx + IW'(1);
                     w_nxt_state = ST_UP_LOAD;
                  end
               end else if (r_pg_cnt == PG_LAST) begin
                  w_nxt_state      = ST_FAULT;
                  w_nxt_rail_en    = '0;
                  w_nxt_fault_rail = r_idx;
               end else if (r_pg_cnt != '1) begin
                  w_nxt_pg_cnt = r_pg_cnt + 32'd1;
               end
            end
            ST_ON: begin
               if (w_abort) begin
                  w_nxt_state = ST_DN_LOAD;
                  w_nxt_idx   = LAST_IDX;
               end
            end
            ST_DN_LOAD: w_nxt_state = ST_DN_WAIT;
            ST_DN_WAIT: begin
               if (tmr_timeout) begin
                  w_nxt_rail_en[r_idx] = 1'b0;
                  if (r_idx == '0) begin
                     w_nxt_state = ST_OFF;
                  end else begin
                     w_nxt_idx   = r_idx - IW'(1);
                     w_nxt_state = ST_DN_LOAD;
                  end
               end
            end
            ST_FAULT: begin
               if (clear_fault && !start) w_nxt_state = ST_OFF;
            end
            default: w_nxt_state = ST_OFF;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_state      <= ST_OFF;
         r_idx        <= '0;
         r_pg_cnt     <= '0;
         r_rail_en    <= '0;
         r_fault_rail <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_idx        <= w_nxt_idx;
         r_pg_cnt     <= w_nxt_pg_cnt;
         r_rail_en    <= w_nxt_rail_en;
         r_fault_rail <= w_nxt_fault_rail;
      end
   end

   // Timer load value, decoded from the state register.
   always_comb begin
      tmr_data = '0;
      if (r_state == ST_UP_LOAD)      tmr_data = w_delay_arr[r_idx];
      else if (r_state == ST_DN_LOAD) tmr_data = DN_LOAD_VAL;
   end

   assign tmr_load   = (r_state == ST_UP_LOAD) || (r_state == ST_DN_LOAD);
   assign tmr_en     = (r_state == ST_UP_WAIT) || (r_state == ST_DN_WAIT);
   assign busy       = w_up_state || w_dn_state;
   assign pwr_ok     = (r_state == ST_ON);
   assign fault      = (r_state == ST_FAULT);
   assign rail_en    = r_rail_en;
   assign fault_rail = r_fault_rail;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl. It contains a behavioural countdown timer and
// a power-good model that follows rail_en two cycles late. Individual rails can
// be forced low.
module tb_pwr_seq_ctrl;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            stop;
   logic            clear_fault;
   logic [N*DW-1:0] delay_up;
   logic [N-1:0]    pgood;
   logic            tmr_timeout;
   logic            tmr_load;
   logic [DW-1:0]   tmr_data;
   logic            tmr_en;
   logic [N-1:0]    rail_en;
   logic            pwr_ok;
   logic            busy;
   logic            fault;
   logic [IW-1:0]   fault_rail;

   logic [N-1:0]    pg_d1;
   logic [N-1:0]    pg_d2;
   logic [N-1:0]    pg_force;
   logic [DW-1:0]   t_cnt;

   int checks   = 0;
   int failures = 0;

   pwr_seq_ctrl #(
      .N_RAILS(N), .IW(IW), .DW(DW), .PG_TIMEOUT(10), .DN_DELAY(3)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear_fault(clear_fault),
      .delay_up(delay_up), .pgood(pgood), .tmr_timeout(tmr_timeout),
      .tmr_load(tmr_load), .tmr_data(tmr_data), .tmr_en(tmr_en), .rail_en(rail_en),
      .pwr_ok(pwr_ok), .busy(busy), .fault(fault), .fault_rail(fault_rail)
   );

   always #5 clk = ~clk;

   // External countdown timer.
   always @(posedge clk) begin
      if (reset) begin
         t_cnt       <= '0;
         tmr_timeout <= 1'b0;
      end else begin
         if (tmr_load)                  t_cnt <= tmr_data;
         else if (tmr_en && t_cnt != 0) t_cnt <= t_cnt - 1;
         tmr_timeout <= tmr_en && (t_cnt == 0);
      end
   end

   // Power-good follows rail_en two cycles late.
   always @(posedge clk) begin
      if (reset) begin
         pg_d1 <= '0;
         pg_d2 <= '0;
      end else begin
         pg_d1 <= rail_en;
         pg_d2 <= pg_d1;
      end
   end
   assign pgood = pg_d2 & ~pg_force;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0; clear_fault = 1'b0; pg_force = '0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rail_en !== 4'b0000) begin failures++; $display("FAIL rst_rail_en: got %b exp 0000", rail_en); end
      checks++; if ({pwr_ok, busy, fault} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b exp 000", {pwr_ok, busy, fault}); end
      checks++; if (fault_rail !== 2'd0) begin failures++; $display("FAIL rst_fault_rail: got %0d exp 0", fault_rail); end
      checks++; if ({tmr_load, tmr_en} !== 2'b00 || tmr_data !== 32'd0) begin failures++; $display("FAIL rst_timer: got load=%b en=%b data=%0d exp 0/0/0", tmr_load, tmr_en, tmr_data); end
   endtask

   // Full power-up from cycle 0, ending in ON at cycle 45.
   task automatic test_powerup();
      do_reset();
      start = 1'b1;
      tick(1); // cycle 1
      checks++; if (tmr_load !== 1'b1 || tmr_data !== 32'd5) begin failures++; $display("FAIL pu_load: got load=%b data=%0d exp 1/5", tmr_load, tmr_data); end
      checks++; if (busy !== 1'b1 || tmr_en !== 1'b0) begin failures++; $display("FAIL pu_busy: got busy=%b en=%b exp 1/0", busy, tmr_en); end
      tick(1); // cycle 2
      checks++; if (tmr_en !== 1'b1 || tmr_load !== 1'b0) begin failures++; $display("FAIL pu_wait: got en=%b load=%b exp 1/0", tmr_en, tmr_load); end
      tick(6); // cycle 8
      checks++; if (rail_en !== 4'b0000) begin failures++; $display("FAIL pu_rail0_early: got %b exp 0000", rail_en); end
      tick(1); // cycle 9
      checks++; if (rail_en !== 4'b0001) begin failures++; $display("FAIL pu_rail0_c9: got %b exp 0001", rail_en); end
      tick(11); // cycle 20
      checks++; if (rail_en !== 4'b0011) begin failures++; $display("FAIL pu_rail1_c20: got %b exp 0011", rail_en); end
      tick(22); // cycle 42
      checks++; if (rail_en !== 4'b1111 || pwr_ok !== 1'b0) begin failures++; $display("FAIL pu_rail3_c42: got rail=%b ok=%b exp 1111/0", rail_en, pwr_ok); end
      tick(2); // cycle 44
      checks++; if (busy !== 1'b1 || pwr_ok !== 1'b0) begin failures++; $display("FAIL pu_pg_c44: got busy=%b ok=%b exp 1/0", busy, pwr_ok); end
      tick(1); // cycle 45
      checks++; if (pwr_ok !== 1'b1 || busy !== 1'b0 || rail_en !== 4'b1111) begin failures++; $display("FAIL pu_on: got ok=%b busy=%b rail=%b exp 1/0/1111", pwr_ok, busy, rail_en); end
   endtask

   // Power-down from ON. Rails clear every 6 cycles in order 3,2,1,0.
   task automatic test_powerdown();
      start = 1'b0;
      tick(1); // d0: DN_LOAD
      checks++; if (tmr_load !== 1'b1 || tmr_data !== 32'd3 || pwr_ok !== 1'b0) begin failures++; $display("FAIL pd_load: got load=%b data=%0d ok=%b exp 1/3/0", tmr_load, tmr_data, pwr_ok); end
      tick(5); // d0+5
      checks++; if (rail_en !== 4'b1111) begin failures++; $display("FAIL pd_hold: got %b exp 1111", rail_en); end
      tick(1); // d0+6
      checks++; if (rail_en !== 4'b0111) begin failures++; $display("FAIL pd_rail3: got %b exp 0111", rail_en); end
      tick(6);
      checks++; if (rail_en !== 4'b0011) begin failures++; $display("FAIL pd_rail2: got %b exp 0011", rail_en); end
      tick(6);
      checks++; if (rail_en !== 4'b0001) begin failures++; $display("FAIL pd_rail1: got %b exp 0001", rail_en); end
      tick(5); // d0+23
      checks++; if (rail_en !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL pd_rail0_early: got rail=%b busy=%b exp 0001/1", rail_en, busy); end
      tick(1); // d0+24
      checks++; if (rail_en !== 4'b0000 || busy !== 1'b0 || fault !== 1'b0 || tmr_load !== 1'b0) begin failures++; $display("FAIL pd_off: got rail=%b busy=%b fault=%b load=%b exp 0000/0/0/0", rail_en, busy, fault, tmr_load); end
   endtask

   // pgood[2] never rises. UP_PG for rail 2 starts at cycle 31, so FAULT comes at cycle 41.
   task automatic test_pg_timeout();
      do_reset();
      pg_force = 4'b0100;
      start = 1'b1;
      tick(31);
      checks++; if (rail_en !== 4'b0111) begin failures++; $display("FAIL pgto_rail2_on: got %b exp 0111", rail_en); end
      tick(9); // cycle 40
      checks++; if (fault !== 1'b0 || busy !== 1'b1 || rail_en !== 4'b0111) begin failures++; $display("FAIL pgto_early: got fault=%b busy=%b rail=%b exp 0/1/0111", fault, busy, rail_en); end
      tick(1); // cycle 41
      checks++; if (fault !== 1'b1 || rail_en !== 4'b0000 || fault_rail !== 2'd2 || busy !== 1'b0) begin failures++; $display("FAIL pgto_fault: got fault=%b rail=%b idx=%0d busy=%b exp 1/0000/2/0", fault, rail_en, fault_rail, busy); end
      start = 1'b0; clear_fault = 1'b1; pg_force = '0;
      tick(1);
      clear_fault = 1'b0;
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL pgto_clear: got fault=%b exp 0", fault); end
   endtask

   // A one-cycle pgood[1] glitch in ON faults immediately. The clear is honoured only with start low.
   task automatic test_pg_loss();
      do_reset();
      start = 1'b1;
      tick(47);
      checks++; if (pwr_ok !== 1'b1) begin failures++; $display("FAIL loss_on: got ok=%b exp 1", pwr_ok); end
      pg_force = 4'b0010;
      tick(1);
      pg_force = '0;
      checks++; if (fault !== 1'b1 || fault_rail !== 2'd1 || rail_en !== 4'b0000 || pwr_ok !== 1'b0) begin failures++; $display("FAIL loss_fault: got fault=%b idx=%0d rail=%b ok=%b exp 1/1/0000/0", fault, fault_rail, rail_en, pwr_ok); end
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL loss_clear_ignored: got fault=%b exp 1", fault); end
      start = 1'b0;
      tick(1);
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL loss_hold: got fault=%b exp 1", fault); end
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      checks++; if (fault !== 1'b0 || busy !== 1'b0 || pwr_ok !== 1'b0) begin failures++; $display("FAIL loss_cleared: got fault=%b busy=%b ok=%b exp 0/0/0", fault, busy, pwr_ok); end
   endtask

   // stop during UP_WAIT for rail 2 at cycle 26, followed by reverse unwind of rails 1 and 0.
   task automatic test_abort();
      logic rail2_seen;
      rail2_seen = 1'b0;
      do_reset();
      start = 1'b1;
      tick(26);
      checks++; if (tmr_en !== 1'b1 || rail_en !== 4'b0011) begin failures++; $display("FAIL ab_pre: got en=%b rail=%b exp 1/0011", tmr_en, rail_en); end
      stop = 1'b1;
      tick(1); // cycle 27
      checks++; if (tmr_load !== 1'b1 || tmr_data !== 32'd3 || rail_en !== 4'b0011) begin failures++; $display("FAIL ab_dnload: got load=%b data=%0d rail=%b exp 1/3/0011", tmr_load, tmr_data, rail_en); end
      for (int c = 28; c <= 39; c++) begin
         tick(1);
         if (rail_en[2]) rail2_seen = 1'b1;
         if (c == 33) begin
            checks++; if (rail_en !== 4'b0001) begin failures++; $display("FAIL ab_rail1: got %b exp 0001", rail_en); end
         end
      end
      checks++; if (rail_en !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL ab_off: got rail=%b busy=%b exp 0000/0", rail_en, busy); end
      checks++; if (rail2_seen !== 1'b0) begin failures++; $display("FAIL ab_rail2_never: got %b exp 0", rail2_seen); end
      stop = 1'b0; start = 1'b0;
   endtask

   // start and stop together in OFF produce no sequencing.
   task automatic test_start_stop_off();
      do_reset();
      start = 1'b1; stop = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         checks++; if (tmr_load !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ss_off_c%0d: got load=%b busy=%b exp 0/0", c, tmr_load, busy); end
      end
      start = 1'b0; stop = 1'b0;
   endtask

   // Reset asserted while in UP_PG for rail 0 clears everything on the next edge.
   task automatic test_reset_mid();
      do_reset();
      start = 1'b1;
      tick(10); // cycle 10: UP_PG, rail 0
      checks++; if (rail_en !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL rm_pre: got rail=%b busy=%b exp 0001/1", rail_en, busy); end
      reset = 1'b1; start = 1'b0;
      tick(1);
      checks++; if (rail_en !== 4'b0000 || {pwr_ok, busy, fault, tmr_load, tmr_en} !== 5'b00000 || tmr_data !== 32'd0 || fault_rail !== 2'd0) begin
         failures++; $display("FAIL rm_zero: got rail=%b flags=%b data=%0d idx=%0d exp all 0", rail_en, {pwr_ok, busy, fault, tmr_load, tmr_en}, tmr_data, fault_rail);
      end
      reset = 1'b0;
   endtask

   initial begin
      delay_up = {32'd5, 32'd5, 32'd5, 32'd5};
      test_reset();
      test_powerup();
      test_powerdown();
      test_pg_timeout();
      test_pg_loss();
      test_abort();
      test_start_stop_off();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
Power-rail sequencing controller. It drives the countdown-timer interface (load, data, enable) and consumes its timeout pulse. It uses these to space rail enables on power-up, space rail disables in reverse order on power-down, and supervise per-rail power-good. The block sits between the host control register bank and the rail enable pins, with one timer instance dedicated to it.

Parameters:
N_RAILS, 4, number of sequenced rails (2..16)
IW, 2, rail index width, ceil(log2(N_RAILS))
DW, 32, timer data width
PG_TIMEOUT, 1000, cycles allowed for pgood to assert after a rail is enabled (>=1)
DN_DELAY, 100, timer load value used between rail disables on power-down

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  level; request power-up
stop  in  1  level; request power-down; wins over start
clear_fault  in  1  pulse; leave FAULT
delay_up  in  N_RAILS*DW  per-rail power-up delay; rail i in bits [i*DW +: DW]
pgood  in  N_RAILS  per-rail power-good, synchronous to clk
tmr_timeout  in  1  timer expiry
tmr_load  out  1  timer load strobe
tmr_data  out  DW  timer load value
tmr_en  out  1  timer count enable
rail_en  out  N_RAILS  registered rail enables
pwr_ok  out  1  all rails up
busy  out  1  sequencing in progress
fault  out  1  fault latched
fault_rail  out  IW  index of the faulting rail

Behaviour:
- Reset: state OFF, idx=0, pg_cnt=0, rail_en=0, pwr_ok=0, busy=0, fault=0, fault_rail=0; tmr_load=0, tmr_en=0, tmr_data=0. Reset mid-sequence drops all rails on the next edge.
- Timer contract (external): a tmr_load cycle captures tmr_data. While tmr_en=1 the count decrements once per cycle. tmr_timeout is registered high in each cycle the count is 0 with enable high. A load of D therefore yields tmr_timeout visible D+2 cycles after the load cycle.
- Timer outputs are decoded from the state register (Moore):
  - tmr_load=1 only in UP_LOAD and DN_LOAD.
  - tmr_en=1 only in UP_WAIT and DN_WAIT.
  - tmr_data = delay_up[idx] in UP_LOAD, DN_DELAY in DN_LOAD, and 0 otherwise.
- busy=1 in UP_* and DN_*. pwr_ok=1 only in ON.
- tmr_timeout is sampled only in UP_WAIT and DN_WAIT and ignored in all other states, including any stale high cycle.
- States and transitions:
  - OFF: stop=0 and start=1 -> UP_LOAD, idx=0.
  - UP_LOAD (1 cycle) -> UP_WAIT.
  - UP_WAIT: tmr_timeout=1 -> set rail_en[idx], pg_cnt=0, go to UP_PG.
  - UP_PG:
    - pgood[idx]=1 -> if idx==N_RAILS-1 go to ON, else idx+1 and UP_LOAD.
    - pgood[idx]=0 -> pg_cnt+1; when pg_cnt reaches PG_TIMEOUT-1 (pgood still low), fault_rail=idx and go to FAULT.
  - ON: stop=1, or start=0, -> DN_LOAD with idx=N_RAILS-1.
  - DN_LOAD (1 cycle) -> DN_WAIT.
  - DN_WAIT: tmr_timeout=1 -> clear rail_en[idx]; if idx==0 go to OFF, else idx-1 and DN_LOAD.
  - FAULT: rail_en=0 on entry (all rails in the same edge), fault=1. clear_fault=1 with start=0 -> OFF with fault=0. clear_fault while start=1 is ignored.
- Abort during power-up (stop=1, or start deasserted, in any UP_* state):
  - In UP_LOAD or UP_WAIT: rail idx is not yet enabled. If idx==0 go to OFF; else go to DN_LOAD with idx-1.
  - In UP_PG: go to DN_LOAD with idx unchanged.
- Supervision:
  - In UP_* and ON, any enabled rail j below the rail under test (or any rail in ON) with pgood[j]=0 -> FAULT with fault_rail=j. The lowest such j wins.
  - Supervision has priority over abort and over timer events in the same cycle.
  - pgood is ignored in OFF, DN_* and FAULT.
- Simultaneous events: stop+start -> stop. pgood loss + tmr_timeout -> FAULT.
- Arithmetic:
  - pg_cnt is unsigned, 32 bits, and saturating.
  - idx never wraps; bounds are checked before increment or decrement.
  - delay_up is sampled only in UP_LOAD; changes at any other time have no effect.

Test Plan:
- Bench setup: block connected to the timer with N_RAILS=4, delay_up={5,5,5,5}, pgood tied to rail_en delayed 2 cycles.
  - Start at cycle 0 -> tmr_load in cycle 1 with tmr_data=5; rail_en[0] rises in cycle 9.
  - rail_en reaches 4'b1111, then pwr_ok=1; busy=0 in ON.
- Power-down from ON with DN_DELAY=3 -> rails clear in order 3,2,1,0, one per 3+3 cycles, then OFF; fault stays 0.
- pgood[2] held low after rail_en[2] rises, PG_TIMEOUT=10 -> FAULT exactly 10 cycles into UP_PG; rail_en=0; fault=1; fault_rail=2.
- In ON, drop pgood[1] for one cycle -> next edge FAULT, fault_rail=1. clear_fault with start=1 is ignored; after start=0, clear_fault -> OFF, fault=0.
- stop asserted in UP_WAIT for rail 2 -> DN_LOAD with idx=1; rails 1 and 0 clear in reverse order; rail 2 is never enabled.
- start and stop asserted together in OFF -> remain OFF with no tmr_load. Reset asserted in UP_PG -> all outputs 0 on the next edge.
